// File: rtl/sw_cond_pkg.sv
// ---------------------------------------------------------------------------
// sw_cond_pkg
// Shared types and constants for the switch input conditioner.
//   sel_state_t     : selector FSM states (IDLE, HOLD, RELEASE)
//   N_SW_DEFAULT    : default number of board switches
//   DEBOUNCE_SIM    : short debounce window used in simulation builds
//   DEBOUNCE_BOARD  : 20 ms debounce window at 50 MHz for the board build
// ---------------------------------------------------------------------------
package sw_cond_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } sel_state_t;

   localparam int N_SW_DEFAULT   = 4;
   localparam int DEBOUNCE_SIM   = 8;
   localparam int DEBOUNCE_BOARD = 1_000_000;

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch bit: a SYNC_STAGES-deep synchroniser followed by a debounce
// counter. The stable level only follows the synchronised level after it has
// disagreed for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   raw    : asynchronous, possibly bouncing switch pin
//   stable : debounced switch level
// ---------------------------------------------------------------------------
module sw_debounce_bit
   import sw_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_BOARD
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          count;
   logic                   sync_level;

   // Shift the raw pin through the synchroniser chain; every stage is reset
   // so the stable level starts from a known zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
      end
   end

   assign sync_level = sync[SYNC_STAGES-1];

   // Count consecutive cycles where the synchronised level disagrees with the
   // accepted level. Any agreement clears the count, so a short glitch earns
   // no partial credit towards the next change.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         stable <= 1'b0;
      end else if (sync_level == stable) begin
         count <= '0;
      end else if (count == COUNT_LAST) begin
         stable <= sync_level;
         count  <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sw_input_conditioner.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner
// Turns raw board switches into a clean one-hot switch command for the LED
// pattern FSM. Each bit is synchronised and debounced, then a selector FSM
// picks at most one switch at a time (lowest index wins).
// Optional build macro SW_CONDITIONER_LATCH_EN selects latched mode: the
// selection survives release, a new press elsewhere replaces it, and a
// re-press of the selected switch clears it. Without the macro the command
// is momentary and drops when the selected switch is released.
// Ports:
//   i_clk       : 50 MHz system clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_sw_raw    : raw asynchronous switch pins
//   o_sw        : one-hot (or zero) switch command
//   o_idx       : index of the selected switch, 0 when none
//   o_sel_pulse : one-cycle strobe when a new selection is made
//   o_stable    : debounced per-bit levels (debug)
// ---------------------------------------------------------------------------
module sw_input_conditioner
   import sw_cond_pkg::*;
#(
   parameter int N_SW            = N_SW_DEFAULT,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_SW-1:0]         i_sw_raw,
   output logic [N_SW-1:0]         o_sw,
   output logic [$clog2(N_SW)-1:0] o_idx,
   output logic                    o_sel_pulse,
   output logic [N_SW-1:0]         o_stable
);

   localparam int IW = $clog2(N_SW);

   logic [N_SW-1:0] stable;
   sel_state_t      state;
   sel_state_t      state_next;
   logic [N_SW-1:0] sw_next;
   logic [IW-1:0]   idx_next;
   logic            pulse_next;

   // Lowest set bit of a vector; 0 when the vector is empty.
   function automatic logic [IW-1:0] lowest_index(input logic [N_SW-1:0] bits);
      lowest_index = '0;
      for (int i = N_SW - 1; i >= 0; i--) begin
         if (bits[i]) begin
            lowest_index = IW'(i);
         end
      end
   endfunction

   for (genvar g = 0; g < N_SW; g++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (i_clk),
         .rst    (i_rst),
         .raw    (i_sw_raw[g]),
         .stable (stable[g])
      );
   end

   assign o_stable = stable;

`ifdef SW_CONDITIONER_LATCH_EN
   logic [N_SW-1:0] prev_stable;
   logic [N_SW-1:0] rises;

   // Previous debounced levels, so a new press can be told apart from a
   // switch that has simply stayed down.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_stable <= '0;
      end else begin
         prev_stable <= stable;
      end
   end

   assign rises = stable & ~prev_stable;
`endif

   // Selector state and registered command outputs; the command is
   // registered so it is glitch-free towards the pattern FSM.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         o_sw        <= '0;
         o_idx       <= '0;
         o_sel_pulse <= 1'b0;
      end else begin
         state       <= state_next;
         o_sw        <= sw_next;
         o_idx       <= idx_next;
         o_sel_pulse <= pulse_next;
      end
   end

   // Next selection. RELEASE waits for every switch to be let go, so a
   // second switch that is still held never takes over without a re-press.
   always_comb begin
      state_next = state;
      sw_next    = o_sw;
      idx_next   = o_idx;
      pulse_next = 1'b0;
      case (state)
         IDLE: begin
            sw_next  = '0;
            idx_next = '0;
            if (|stable) begin
               idx_next   = lowest_index(stable);
               sw_next    = N_SW'(1) << lowest_index(stable);
               pulse_next = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
`ifdef SW_CONDITIONER_LATCH_EN
            if (|rises) begin
               if (lowest_index(rises) == o_idx) begin
                  sw_next    = '0;
                  idx_next   = '0;
                  state_next = RELEASE;
               end else begin
                  idx_next   = lowest_index(rises);
                  sw_next    = N_SW'(1) << lowest_index(rises);
                  pulse_next = 1'b1;
               end
            end
`else
            if (!stable[o_idx]) begin
               sw_next    = '0;
               idx_next   = '0;
               state_next = RELEASE;
            end
`endif
         end
         RELEASE: begin
            sw_next  = '0;
            idx_next = '0;
            if (!(|stable)) begin
               state_next = IDLE;
            end
         end
         default: begin
            sw_next    = '0;
            idx_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sw_input_conditioner
// Self-checking bench for sw_input_conditioner with default parameters.
// A behavioural model (raw delay line, sliding debounce window, selection
// rules) predicts every output each cycle; directed sequences pin the model
// with literal latencies and values. Honours SW_CONDITIONER_LATCH_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sw_input_conditioner;

   localparam int NSW = 4;
   localparam int DEB = 8;
   localparam int LAT = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw;
   logic [3:0] oSw;
   logic [1:0] oIdx;
   logic       oSelPulse;
   logic [3:0] oStable;

   int checks = 0;
   int errors = 0;
   int pulseCount = 0;
   int edges;
   int badCount;

   // Model state
   bit         modelOn = 1'b0;
   logic [3:0] delayLine [2];
   bit         win [NSW][DEB];
   logic [3:0] mStable;
   logic [3:0] mPrev;
   logic [3:0] st;
   logic [3:0] rises;
   logic [3:0] expSw;
   logic [1:0] expIdx;
   logic       expPulse;
   int         mSel;
   bit         mReleasing;
   bit         allOpp;

   always #10 clk = ~clk;

   sw_input_conditioner #(
      .N_SW            (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sw_raw    (raw),
      .o_sw        (oSw),
      .o_idx       (oIdx),
      .o_sel_pulse (oSelPulse),
      .o_stable    (oStable)
   );

   function automatic int lowestOf(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (oSelPulse === 1'b1) pulseCount++;
   endtask

   task automatic holdCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic applyStimulus(input logic [3:0] v);
      @(negedge clk);
      raw = v;
   endtask

   task automatic waitForSw(input logic [3:0] want, input int limit, output int count);
      count = -1;
      for (int i = 1; i <= limit; i++) begin
         stepCycle();
         if (oSw === want) begin
            count = i;
            break;
         end
      end
   endtask

   // Behavioural model: raw is seen by the debouncer two edges later; a bit
   // flips once the last DEB samples all disagree with its accepted level.
   // The selection is judged on the accepted levels from before this edge.
   always @(posedge clk) begin
      if (rst) begin
         modelOn      = 1'b1;
         delayLine[0] = '0;
         delayLine[1] = '0;
         for (int b = 0; b < NSW; b++)
            for (int k = 0; k < DEB; k++) win[b][k] = 1'b0;
         mStable    = '0;
         mPrev      = '0;
         mSel       = -1;
         mReleasing = 1'b0;
         expPulse   = 1'b0;
      end else if (modelOn) begin
         st       = mStable;
         expPulse = 1'b0;
         if (mReleasing) begin
            if (st == 4'b0000) mReleasing = 1'b0;
         end else if (mSel < 0) begin
            if (st != 4'b0000) begin
               mSel     = lowestOf(st);
               expPulse = 1'b1;
            end
         end else begin
`ifdef SW_CONDITIONER_LATCH_EN
            rises = st & ~mPrev;
            if (rises != 4'b0000) begin
               if (lowestOf(rises) == mSel) begin
                  mSel       = -1;
                  mReleasing = 1'b1;
               end else begin
                  mSel     = lowestOf(rises);
                  expPulse = 1'b1;
               end
            end
`else
            if (st[mSel] == 1'b0) begin
               mSel       = -1;
               mReleasing = 1'b1;
            end
`endif
         end
         mPrev = st;
         for (int b = 0; b < NSW; b++) begin
            for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = delayLine[1][b];
            allOpp = 1'b1;
            for (int k = 0; k < DEB; k++)
               if (win[b][k] == mStable[b]) allOpp = 1'b0;
            if (allOpp) mStable[b] = ~mStable[b];
         end
         delayLine[1] = delayLine[0];
         delayLine[0] = raw;
      end
      expSw  = (mSel >= 0) ? (4'b0001 << mSel) : 4'b0000;
      expIdx = (mSel >= 0) ? mSel[1:0] : 2'd0;
      if (modelOn) begin
         #1;
         checkOutput("model_sw", oSw, expSw);
         checkOutput("model_idx", oIdx, expIdx);
         checkOutput("model_pulse", oSelPulse, expPulse);
         checkOutput("model_stable", oStable, mStable);
         checkOutput("onehot0", $onehot0(oSw), 1);
      end
   end

   // Directed sequences with literal expectations, then random traffic.
   initial begin
      rst = 1'b1;
      raw = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("reset_sw", oSw, 4'b0000);
         checkOutput("reset_idx", oIdx, 2'd0);
         checkOutput("reset_pulse", oSelPulse, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      stepCycle();
      checkOutput("first_edge_sw", oSw, 4'b0000);
      checkOutput("first_edge_pulse", oSelPulse, 1'b0);
      waitForSw(4'b0001, 40, edges);
      checkOutput("reset_release_latency", (edges < 0) ? -1 : edges + 1, LAT);

      applyStimulus(4'b0000);
      @(negedge clk);
      rst = 1'b1;
      holdCycles(2);
      @(negedge clk);
      rst = 1'b0;
      holdCycles(15);

`ifdef SW_CONDITIONER_LATCH_EN
      applyStimulus(4'b0001);
      waitForSw(4'b0001, 40, edges);
      checkOutput("latch_press_latency", edges, LAT);
      holdCycles(5);
      applyStimulus(4'b0000);
      holdCycles(30);
      checkOutput("latch_keep_sw", oSw, 4'b0001);

      pulseCount = 0;
      applyStimulus(4'b0100);
      waitForSw(4'b0100, 40, edges);
      checkOutput("latch_replace_latency", edges, LAT);
      holdCycles(5);
      applyStimulus(4'b0000);
      holdCycles(30);
      checkOutput("latch_replace_sw", oSw, 4'b0100);
      checkOutput("latch_replace_idx", oIdx, 2'd2);
      checkOutput("latch_replace_pulses", pulseCount, 1);

      applyStimulus(4'b0100);
      waitForSw(4'b0000, 40, edges);
      checkOutput("latch_repress_clear", edges, LAT);
      applyStimulus(4'b0000);
      holdCycles(20);
`else
      pulseCount = 0;
      applyStimulus(4'b0001);
      waitForSw(4'b0001, 40, edges);
      checkOutput("press_latency", edges, LAT);
      checkOutput("press_idx", oIdx, 2'd0);
      holdCycles(25 - LAT);
      checkOutput("press_pulses", pulseCount, 1);
      applyStimulus(4'b0000);
      waitForSw(4'b0000, 40, edges);
      checkOutput("release_latency", edges, LAT);
      holdCycles(10);

      badCount = 0;
      for (int seg = 0; seg < 5; seg++) begin
         applyStimulus((seg % 2 == 0) ? 4'b0010 : 4'b0000);
         if (seg < 4) begin
            for (int i = 0; i < 3; i++) begin
               stepCycle();
               if (oSw !== 4'b0000) badCount++;
            end
         end
      end
      waitForSw(4'b0010, 40, edges);
      checkOutput("bounce_quiet", badCount, 0);
      checkOutput("bounce_latency", edges, LAT);
      checkOutput("bounce_idx", oIdx, 2'd1);
      applyStimulus(4'b0000);
      holdCycles(20);

      applyStimulus(4'b0110);
      waitForSw(4'b0010, 40, edges);
      checkOutput("simul_latency", edges, LAT);
      checkOutput("simul_idx", oIdx, 2'd1);
      applyStimulus(4'b0100);
      waitForSw(4'b0000, 40, edges);
      checkOutput("simul_release_latency", edges, LAT);
      badCount = 0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (oSw !== 4'b0000) badCount++;
      end
      checkOutput("no_takeover", badCount, 0);
      applyStimulus(4'b0000);
      holdCycles(15);
      applyStimulus(4'b1000);
      waitForSw(4'b1000, 40, edges);
      checkOutput("top_bit_latency", edges, LAT);
      checkOutput("top_bit_idx", oIdx, 2'd3);
      applyStimulus(4'b0000);
      holdCycles(15);

      applyStimulus(4'b0100);
      waitForSw(4'b0100, 40, edges);
      holdCycles(5);
      @(negedge clk);
      rst = 1'b1;
      stepCycle();
      checkOutput("hold_reset_sw", oSw, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      pulseCount = 0;
      waitForSw(4'b0100, 40, edges);
      checkOutput("reselect_latency", edges, LAT);
      checkOutput("reselect_pulse", oSelPulse, 1'b1);
      checkOutput("reselect_pulses", pulseCount, 1);
      applyStimulus(4'b0000);
      holdCycles(15);
`endif

      // Random traffic; hold lengths straddle the debounce window.
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            rst = 1'b1;
            stepCycle();
            @(negedge clk);
            rst = 1'b0;
         end
         if ($urandom_range(0, 1) == 0)
            applyStimulus(4'b0001 << $urandom_range(0, 3));
         else
            applyStimulus(4'($urandom));
         holdCycles($urandom_range(1, 20));
      end

      applyStimulus(4'b0000);
      holdCycles(30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
